clk_divider_prog: RTL and testbench
===================================

CLK_DIVIDER_PROG -- requirements
Module: clk_divider_prog

Interface
REQ-001 Parameter CNT_W, default 26: bit width of the counter, Half_in and Half_cur.
REQ-002 Parameter DEFAULT_HALF, default 25000000: half-period, in Clk cycles, loaded at reset; legal range 1..2^CNT_W-1.
REQ-003 Clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Rst_n  input  1  reset, synchronous, active-low.
REQ-005 En  input  1  count enable; low freezes all divider state.
REQ-006 Half_in  input  CNT_W  requested half-period, in Clk cycles.
REQ-007 Load  input  1  single-cycle strobe; captures Half_in into the pending register.
REQ-008 Clk_out  output  1  registered divided clock, 50% duty cycle.
REQ-009 Tick  output  1  registered one-cycle pulse marking every Clk_out transition.
REQ-010 Pending  output  1  high while a loaded half-period awaits application.
REQ-011 Half_cur  output  CNT_W  half-period currently in effect.

Function
REQ-012 Internal state SHALL be: counter cnt (CNT_W bits), active half-period H (drives Half_cur), pending value P, pending flag (drives Pending).
REQ-013 Wrap condition SHALL be En=1 and cnt >= H-1; the >= comparison is required, not ==.
REQ-014 On a wrap edge: cnt <= 0; Clk_out <= ~Clk_out; Tick <= 1.
REQ-015 On an edge with En=1 and no wrap: cnt <= cnt+1; Tick <= 0; Clk_out holds.
REQ-016 On an edge with En=0: cnt and Clk_out hold; Tick <= 0; counting resumes from the held cnt once En returns high.
REQ-017 Consequence of REQ-013..016: with En held high, Clk_out period is 2*H Clk cycles and Tick fires every H cycles.
REQ-018 Load=1 SHALL capture P <= max(Half_in,1) and set Pending <= 1; Half_in=0 is stored as 1.
REQ-019 Load while Pending=1: P is overwritten; the latest value wins and Pending stays 1.
REQ-020 Pending value SHALL be applied (H <= P, Pending <= 0) on a wrap edge when Pending=1 at that edge, with no Load on that edge.
REQ-021 Pending value SHALL also be applied at the first edge where En=0, Pending=1 and Load=0, so a stopped divider takes the new rate immediately.
REQ-022 Load coinciding with a wrap edge: the wrap uses the old H; the new value is captured per REQ-018 and is applied at the next wrap, not at the coinciding one.
REQ-023 H SHALL never change except per REQ-020, REQ-021 or reset; a cycle in progress always completes with the H it started with.
REQ-024 With H=1 and En=1, Clk_out SHALL toggle every cycle and Tick SHALL stay constantly high.
REQ-025 Counter arithmetic is unsigned, CNT_W bits; cnt never exceeds H-1 in normal operation and cannot overflow.

Reset
REQ-026 Rst_n=0 sampled at a rising edge SHALL set: cnt=0, Clk_out=0, Tick=0, H=DEFAULT_HALF, P=DEFAULT_HALF, Pending=0.
REQ-027 Reset SHALL take priority over En and Load; a Load on a reset edge is discarded.
REQ-028 Reset asserted mid-period SHALL abort the period; the first Tick after release occurs H cycles after the first enabled edge.

Verification
REQ-029 DEFAULT_HALF=3, En=1 after reset -> Clk_out 0,0,0,1,1,1,0... (period 6); Tick high on cycles 3, 6, 9; Half_cur=3.
REQ-030 H=3 running; Load with Half_in=5 at cnt=1 -> Pending=1; the next wrap still occurs at cnt=2, then H=5 and Pending=0; the following half-period lasts 5 cycles.
REQ-031 Load with Half_in=0 -> Half_cur becomes 1 at the next wrap; Clk_out toggles every cycle and Tick stays high.
REQ-032 H=4 running; En low for 7 cycles at cnt=2 -> Clk_out and cnt frozen, Tick=0; after En returns high, the wrap occurs 2 enabled cycles later.
REQ-033 En=0; Load Half_in=8 -> Pending=1 for one cycle, then Half_cur=8 and Pending=0; two successive Loads 9 then 10 -> Half_cur=10 is applied.
REQ-034 Rst_n=0 at cnt=2 with Pending=1 -> next cycle: Clk_out=0, Tick=0, Pending=0, Half_cur=DEFAULT_HALF.

Source files
------------

// File: rtl/clk_divider_prog.sv
// Programmable clock divider.
// Clk_out toggles every Half_cur enabled Clk cycles, and Tick pulses for one
// cycle on each toggle. A new half-period is loaded into a pending register and
// only takes effect on a wrap, or at once while the divider is stopped, so a
// half-period that has already started always completes at the old rate.
//
// Handshake: there is no valid/ready pair. Load is a single-cycle strobe that
// is always accepted. Pending stays high from the edge that captures the value
// until the edge that applies it.
module clk_divider_prog #(
  parameter int CNT_W        = 26,
  parameter int DEFAULT_HALF = 25000000
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             En,
  input  logic [CNT_W-1:0] Half_in,
  input  logic             Load,
  output logic             Clk_out,
  output logic             Tick,
  output logic             Pending,
  output logic [CNT_W-1:0] Half_cur
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(DEFAULT_HALF);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] pend_half;
  logic [CNT_W-1:0] load_val;
  logic             wrap;

  // Wrap test uses >= so that a half-period shortened while stopped can never
  // leave the counter stranded above the new limit.
  always_comb begin
    wrap     = En && (cnt >= (Half_cur - ONE));
    load_val = (Half_in == '0) ? ONE : Half_in;
  end

  // Counter, divided clock, tick pulse and half-period update.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt       <= '0;
      Clk_out   <= 1'b0;
      Tick      <= 1'b0;
      Half_cur  <= HALF_RST;
      pend_half <= HALF_RST;
      Pending   <= 1'b0;
    end else begin
      if (wrap) begin
        cnt     <= '0;
        Clk_out <= ~Clk_out;
        Tick    <= 1'b1;
      end else if (En) begin
        cnt  <= cnt + ONE;
        Tick <= 1'b0;
      end else begin
        Tick <= 1'b0;
      end

      // A load always wins over applying, so a load on a wrap edge waits for
      // the following wrap.
      if (Load) begin
        pend_half <= load_val;
        Pending   <= 1'b1;
      end else if (Pending && (wrap || !En)) begin
        Half_cur <= pend_half;
        Pending  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_divider_prog.sv
// Bench for clk_divider_prog: directed vectors, literal expectations at key
// points, and a behavioural model compared against the outputs every cycle.
module tb_clk_divider_prog;

  localparam int CNT_W = 8;
  localparam int DEF_H = 3;

  logic             Clk;
  logic             Rst_n;
  logic             En;
  logic [CNT_W-1:0] Half_in;
  logic             Load;
  logic             Clk_out;
  logic             Tick;
  logic             Pending;
  logic [CNT_W-1:0] Half_cur;

  int total = 0;
  int bad   = 0;

  clk_divider_prog #(.CNT_W(CNT_W), .DEFAULT_HALF(DEF_H)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .En(En), .Half_in(Half_in), .Load(Load),
    .Clk_out(Clk_out), .Tick(Tick), .Pending(Pending), .Half_cur(Half_cur)
  );

  // ---------------- clock ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- behavioural model ----------------
  // run = enabled cycles spent so far in the current half-period.
  bit m_valid = 0;
  int m_run, m_h, m_p;
  bit m_clk, m_tick, m_pend;

  always @(posedge Clk) begin
    bit wr;
    if (!Rst_n) begin
      m_run = 0; m_h = DEF_H; m_p = DEF_H;
      m_clk = 0; m_tick = 0; m_pend = 0; m_valid = 1;
    end else begin
      wr = En && (m_run + 1 >= m_h);
      m_tick = wr;
      if (wr) begin
        m_run = 0;
        m_clk = !m_clk;
      end else if (En) begin
        m_run = m_run + 1;
      end
      if (Load) begin
        m_p = (Half_in == 0) ? 1 : int'(Half_in);
        m_pend = 1;
      end else if (m_pend && (wr || !En)) begin
        m_h = m_p;
        m_pend = 0;
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge Clk) begin
    if (m_valid) begin
      chk("model_clk_out",  int'(Clk_out),  int'(m_clk));
      chk("model_tick",     int'(Tick),     int'(m_tick));
      chk("model_pending",  int'(Pending),  int'(m_pend));
      chk("model_half_cur", int'(Half_cur), m_h);
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic en, input logic rst_n, input logic load,
                      input int hin);
    En = en; Rst_n = rst_n; Load = load; Half_in = CNT_W'(hin);
    @(posedge Clk);
    #1;
  endtask

  task automatic wait_half(input int h, input int budget);
    int n = 0;
    while (int'(Half_cur) != h && n < budget) begin
      step(1, 1, 0, 0);
      n++;
    end
    chk("wait_half_cur", int'(Half_cur), h);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    En = 0; Rst_n = 0; Load = 0; Half_in = '0;

    // Reset, with a load on the reset edges that must be discarded.
    step(0, 0, 1, 7);
    step(0, 0, 1, 7);
    chk("rst_clk_out", int'(Clk_out), 0);
    chk("rst_tick", int'(Tick), 0);
    chk("rst_pending", int'(Pending), 0);
    chk("rst_half_cur", int'(Half_cur), 3);

    // Free run with H=3: Tick on cycles 3, 6, 9.
    for (int i = 1; i <= 9; i++) begin
      step(1, 1, 0, 0);
      chk("run3_tick", int'(Tick), (i % 3 == 0) ? 1 : 0);
      chk("run3_clk_out", int'(Clk_out), (i / 3) % 2);
    end

    // Load 5 at cnt=1: wrap still at old H, then a 5-cycle half-period.
    step(1, 1, 0, 0);
    step(1, 1, 1, 5);
    chk("ld5_pending", int'(Pending), 1);
    chk("ld5_half_old", int'(Half_cur), 3);
    step(1, 1, 0, 0);
    chk("ld5_wrap_tick", int'(Tick), 1);
    chk("ld5_half_new", int'(Half_cur), 5);
    chk("ld5_pending_clr", int'(Pending), 0);
    chk("ld5_clk_out", int'(Clk_out), 0);
    for (int i = 1; i <= 5; i++) begin
      step(1, 1, 0, 0);
      chk("run5_tick", int'(Tick), (i == 5) ? 1 : 0);
    end

    // Load 0 is stored as 1: Tick then stays high.
    step(1, 1, 1, 0);
    chk("ld0_pending", int'(Pending), 1);
    wait_half(1, 10);
    chk("ld0_pending_clr", int'(Pending), 0);
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 0);
      chk("h1_tick", int'(Tick), 1);
    end

    // H=4, then stop for 7 cycles at cnt=2; wrap two enabled cycles later.
    step(1, 1, 1, 4);
    chk("ld4_half_old", int'(Half_cur), 1);
    step(1, 1, 0, 0);
    chk("ld4_half_new", int'(Half_cur), 4);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 0, 0);
      chk("freeze_tick", int'(Tick), 0);
    end
    step(1, 1, 0, 0);
    chk("resume1_tick", int'(Tick), 0);
    step(1, 1, 0, 0);
    chk("resume2_tick", int'(Tick), 1);

    // Stopped divider takes a new rate immediately; latest load wins.
    step(0, 1, 1, 8);
    chk("stop_ld8_pending", int'(Pending), 1);
    chk("stop_ld8_half_old", int'(Half_cur), 4);
    step(0, 1, 0, 0);
    chk("stop_ld8_half", int'(Half_cur), 8);
    chk("stop_ld8_pending_clr", int'(Pending), 0);
    step(0, 1, 1, 9);
    step(0, 1, 1, 10);
    chk("stop_ld10_pending", int'(Pending), 1);
    chk("stop_ld10_half_old", int'(Half_cur), 8);
    step(0, 1, 0, 0);
    chk("stop_ld10_half", int'(Half_cur), 10);

    // Load on a wrap edge: wrap uses old H, new value waits one more period.
    n = 0;
    while (!(m_run == m_h - 1) && n < 20) begin
      step(1, 1, 0, 0);
      n++;
    end
    chk("pre_wrap_reached", (m_run == m_h - 1) ? 1 : 0, 1);
    step(1, 1, 1, 2);
    chk("ldwrap_tick", int'(Tick), 1);
    chk("ldwrap_half_old", int'(Half_cur), 10);
    chk("ldwrap_pending", int'(Pending), 1);
    n = 0;
    do begin
      step(1, 1, 0, 0);
      n++;
    end while (!Tick && n < 15);
    chk("ldwrap_period_len", n, 10);
    chk("ldwrap_half_new", int'(Half_cur), 2);

    // Shrink H while stopped with cnt above the new limit: wrap at once.
    step(1, 1, 1, 9);
    wait_half(9, 4);
    n = 0;
    while (m_run != 6 && n < 20) begin
      step(1, 1, 0, 0);
      n++;
    end
    step(0, 1, 1, 2);
    step(0, 1, 0, 0);
    chk("shrink_half", int'(Half_cur), 2);
    step(1, 1, 0, 0);
    chk("shrink_wrap_tick", int'(Tick), 1);

    // Reset mid-period with a pending value.
    step(1, 1, 1, 6);
    wait_half(6, 4);
    step(1, 1, 0, 0);
    step(1, 1, 1, 7);
    chk("pre_rst_pending", int'(Pending), 1);
    step(1, 0, 1, 5);
    chk("midrst_clk_out", int'(Clk_out), 0);
    chk("midrst_tick", int'(Tick), 0);
    chk("midrst_pending", int'(Pending), 0);
    chk("midrst_half_cur", int'(Half_cur), 3);
    for (int i = 1; i <= 3; i++) begin
      step(1, 1, 0, 0);
      chk("post_rst_tick", int'(Tick), (i == 3) ? 1 : 0);
    end

    @(negedge Clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
